// File: rtl/fetch_if.sv
// Instruction-memory read channel between the fetch stage and instruction memory.
interface fetch_if;
    localparam int unsigned XLEN = 32;

    logic            ImemReq;
    logic [XLEN-1:0] ImemAddr;
    logic            ImemAck;
    logic [XLEN-1:0] ImemData;

    modport master (output ImemReq, ImemAddr, input ImemAck, ImemData);
    modport slave  (input ImemReq, ImemAddr, output ImemAck, ImemData);
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding word read at a time,
// buffers returned words in a small queue and presents one instruction per cycle to decode.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    fetch_if.master     imem,
    input  logic        AnyStall,
    input  logic        Jump_IDM1,
    input  logic [25:0] JumpTgt_IDM1,
    input  logic        ExRedirect_EX,
    input  logic [31:0] ExRedirectPc_EX,
    output logic [31:0] Pc_IF,
    output logic [31:0] FetchData_IF,
    output logic        InstrVal_IF
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_t;

    state_t            state_q, state_d;
    logic              req_d;
    logic [XLEN-1:0]   addr_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic              push, pop;

    logic [XLEN-1:0]   q_pc   [QDEPTH];
    logic [XLEN-1:0]   q_data [QDEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              q_full, q_empty;

    logic              jump_taken, redirect;
    logic [3:0]        jump_hi;
    logic [XLEN-1:0]   redirect_pc;

    // Redirect detection; execute wins over decode because its instruction is older.
    assign jump_taken  = Jump_IDM1 & InstrVal_IF & ~AnyStall;
    assign redirect    = ExRedirect_EX | jump_taken;
    assign jump_hi     = Pc_IF[31:28] + {3'b000, &Pc_IF[27:2]};
    assign redirect_pc = ExRedirect_EX ? ExRedirectPc_EX : {jump_hi, JumpTgt_IDM1, 2'b00};

    assign q_full  = (count_q == CNT_W'(QDEPTH));
    assign q_empty = (count_q == '0);
    assign pop     = ~redirect & ~AnyStall & ~q_empty;

    // Request FSM next-state: issue, wait for ack, or drop an ack made stale by a redirect.
    always_comb begin
        state_d    = state_q;
        req_d      = imem.ImemReq;
        addr_d     = imem.ImemAddr;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!q_full && !redirect) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.ImemAck) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                    if (!redirect) begin
                        push       = 1'b1;
                        fetch_pc_d = imem.ImemAddr + 32'd4;
                    end
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem.ImemAck) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end
    end

    // Request FSM state, fetch PC and memory request registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            imem.ImemReq  <= 1'b0;
            imem.ImemAddr <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            imem.ImemReq  <= req_d;
            imem.ImemAddr <= addr_d;
        end
    end

    // Queue storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail_q]   <= imem.ImemAddr;
            q_data[tail_q] <= imem.ImemData;
        end
    end

    // Queue pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk) begin
        if (!reset_n || redirect) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // IF output register: squash on redirect, hold on stall, else pop or insert a NOP.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            Pc_IF        <= '0;
            FetchData_IF <= '0;
            InstrVal_IF  <= 1'b0;
        end else if (redirect) begin
            FetchData_IF <= '0;
            InstrVal_IF  <= 1'b0;
        end else if (!AnyStall) begin
            if (!q_empty) begin
                Pc_IF        <= q_pc[head_q];
                FetchData_IF <= q_data[head_q];
                InstrVal_IF  <= 1'b1;
            end else begin
                FetchData_IF <= '0;
                InstrVal_IF  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: instruction-memory model, a scoreboard of
// accepted words against the IF output, and directed scenarios for redirects, stall and reset.
module tb_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned QDEPTH   = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        AnyStall, Jump_IDM1, ExRedirect_EX;
    logic [25:0] JumpTgt_IDM1;
    logic [31:0] ExRedirectPc_EX;
    logic [31:0] Pc_IF, FetchData_IF;
    logic        InstrVal_IF;

    fetch_if imem_bus ();

    fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem            (imem_bus),
        .AnyStall        (AnyStall),
        .Jump_IDM1       (Jump_IDM1),
        .JumpTgt_IDM1    (JumpTgt_IDM1),
        .ExRedirect_EX   (ExRedirect_EX),
        .ExRedirectPc_EX (ExRedirectPc_EX),
        .Pc_IF           (Pc_IF),
        .FetchData_IF    (FetchData_IF),
        .InstrVal_IF     (InstrVal_IF)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1000_0010) return 32'h0800_0040;   // J 0x0000040
        return a ^ 32'hC3C3_3C3C;
    endfunction

    // Instruction memory: one-cycle ack pulse mem_delay cycles after the request is seen.
    logic mem_on;
    int   mem_delay;
    initial begin
        int cnt;
        cnt = 0;
        imem_bus.ImemAck  = 1'b0;
        imem_bus.ImemData = '0;
        forever begin
            @(negedge clk);
            if (!mem_on) begin
                cnt = 0;
            end else if (imem_bus.ImemAck) begin
                imem_bus.ImemAck = 1'b0;
                cnt = 0;
            end else if (imem_bus.ImemReq) begin
                cnt++;
                if (cnt >= mem_delay) begin
                    imem_bus.ImemAck  = 1'b1;
                    imem_bus.ImemData = mem_word(imem_bus.ImemAddr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard / reference model state.
    ent_t        exp_q[$];
    logic        exp_val;
    logic [31:0] exp_pc, exp_data, exp_addr;
    logic        drop_pending;

    // Monitor: sample pre-edge values late in the cycle, then check the post-edge state.
    always begin
        logic        p_rst, p_stall, p_jump, p_exr, p_req, p_ack, redir;
        logic [25:0] p_tgt;
        logic [31:0] p_expc, p_addr, p_data, pc4, target;
        int          size0;
        ent_t        e;
        @(negedge clk);
        #3;
        p_rst   = reset_n;          p_stall = AnyStall;
        p_jump  = Jump_IDM1;        p_tgt   = JumpTgt_IDM1;
        p_exr   = ExRedirect_EX;    p_expc  = ExRedirectPc_EX;
        p_req   = imem_bus.ImemReq; p_addr  = imem_bus.ImemAddr;
        p_ack   = imem_bus.ImemAck; p_data  = imem_bus.ImemData;
        @(posedge clk);
        #1;
        size0  = exp_q.size();
        redir  = p_exr | (p_jump & exp_val & ~p_stall);
        pc4    = exp_pc + 32'd4;
        target = p_exr ? p_expc : {pc4[31:28], p_tgt, 2'b00};
        if (!p_rst) begin
            exp_q.delete();
            exp_val = 1'b0; exp_pc = '0; exp_data = '0;
            exp_addr = RESET_PC; drop_pending = 1'b0;
            check("rst_req",  {31'd0, imem_bus.ImemReq}, 32'd0);
            check("rst_addr", imem_bus.ImemAddr, 32'd0);
            check("rst_pc",   Pc_IF, 32'd0);
        end else begin
            if (redir) begin
                exp_val = 1'b0; exp_data = '0;
            end else if (!p_stall) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    exp_val = 1'b1; exp_pc = e.pc; exp_data = e.data;
                end else begin
                    exp_val = 1'b0; exp_data = '0;
                end
            end
            if (p_req && p_ack) begin
                if (redir || drop_pending) begin
                    drop_pending = 1'b0;
                end else begin
                    exp_q.push_back('{pc: p_addr, data: p_data});
                    exp_addr = p_addr + 32'd4;
                end
                check("req_done", {31'd0, imem_bus.ImemReq}, 32'd0);
            end else if (p_req) begin
                if (redir) drop_pending = 1'b1;
                check("req_held",  {31'd0, imem_bus.ImemReq}, 32'd1);
                check("addr_held", imem_bus.ImemAddr, p_addr);
            end else if (imem_bus.ImemReq) begin
                check("issue_ok",  {31'd0, (size0 < QDEPTH) && !redir}, 32'd1);
            end
            if (redir) begin
                exp_q.delete();
                exp_addr = target;
            end
            if (!p_req && imem_bus.ImemReq) check("req_addr", imem_bus.ImemAddr, exp_addr);
            if (exp_val) check("if_pc", Pc_IF, exp_pc);
        end
        check("if_val",  {31'd0, InstrVal_IF}, {31'd0, exp_val});
        check("if_data", FetchData_IF, exp_data);
    end

    task automatic wait_req(input string tag, input logic [31:0] addr, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (imem_bus.ImemReq && imem_bus.ImemAddr == addr) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic ex_redirect(input logic [31:0] pc);
        @(negedge clk);
        ExRedirect_EX = 1'b1; ExRedirectPc_EX = pc;
        @(negedge clk);
        ExRedirect_EX = 1'b0;
    endtask

    initial begin
        logic found;
        reset_n = 1'b0; AnyStall = 1'b0; Jump_IDM1 = 1'b0; JumpTgt_IDM1 = '0;
        ExRedirect_EX = 1'b0; ExRedirectPc_EX = '0;
        mem_on = 1'b1; mem_delay = 1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // 1: streaming from reset, first instruction at RESET_PC
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (InstrVal_IF) found = 1'b1;
        end
        check("t1_valid", {31'd0, found}, 32'd1);
        check("t1_first_pc", Pc_IF, RESET_PC);
        repeat (20) @(negedge clk);

        // 2: stall long enough to fill the queue; no request while full
        AnyStall = 1'b1;
        repeat (6) @(negedge clk);
        check("t2_full_noreq", {31'd0, imem_bus.ImemReq}, 32'd0);
        AnyStall = 1'b0;
        repeat (20) @(negedge clk);

        // 3: J at 0x1000_0010 while the next request is outstanding
        ex_redirect(32'h1000_0010);
        mem_delay = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (InstrVal_IF && Pc_IF == 32'h1000_0010) found = 1'b1;
        end
        check("t3_at_jump", {31'd0, found}, 32'd1);
        check("t3_outstanding", {31'd0, imem_bus.ImemReq}, 32'd1);
        Jump_IDM1 = 1'b1; JumpTgt_IDM1 = 26'h000_0040;
        @(negedge clk);
        Jump_IDM1 = 1'b0;
        check("t3_squash", {31'd0, InstrVal_IF}, 32'd0);
        wait_req("t3_target", 32'h1000_0100, 30);
        mem_delay = 1;
        repeat (10) @(negedge clk);

        // 4: execute redirect, decode jump and ack all in one cycle
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (imem_bus.ImemAck) found = 1'b1;
        end
        check("t4_ack_seen", {31'd0, found}, 32'd1);
        ExRedirect_EX = 1'b1; ExRedirectPc_EX = 32'h0000_0200;
        Jump_IDM1 = 1'b1; JumpTgt_IDM1 = 26'h3FF_FFFF;
        @(negedge clk);
        ExRedirect_EX = 1'b0; Jump_IDM1 = 1'b0;
        wait_req("t4_target", 32'h0000_0200, 20);
        repeat (10) @(negedge clk);

        // 5: reset while waiting, ack arrives during reset
        @(negedge clk);
        #1;
        mem_on = 1'b0; imem_bus.ImemAck = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_bus.ImemReq) found = 1'b1;
        end
        check("t5_in_wait", {31'd0, found}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        imem_bus.ImemAck = 1'b1; imem_bus.ImemData = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_bus.ImemAck = 1'b0; reset_n = 1'b1; mem_on = 1'b1;
        wait_req("t5_reset_pc", RESET_PC, 20);
        repeat (10) @(negedge clk);

        // 6: address wrap past the top of memory
        ex_redirect(32'hFFFF_FFF8);
        wait_req("t6_last", 32'hFFFF_FFFC, 20);
        wait_req("t6_wrap", 32'h0000_0000, 20);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
